// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-master round-robin arbiter and sequencer for a 32x8 single-port data
//   memory. Each transaction is IDLE -> ACCESS -> RESP:
//     IDLE   : requests are sampled and one winner is latched.
//     ACCESS : the winner's request is driven onto the memory port.
//     RESP   : the winner sees ACK together with its RDATA/ERR.
//   All outputs are registered, so there is no combinational path from REQ.
//
// Parameters
//   DEPTH : number of valid memory words; addresses >= DEPTH are errors
//   AW    : address width
//   DW    : data width
//
// Ports
//   CLK, RESET_N          : clock (rising edge), asynchronous active-low reset
//   REQx/WEx/ADDRx/WDATAx : request from master x, held until GNTx
//   GNTx                  : high during master x's memory-access cycle
//   ACKx                  : one-cycle completion pulse
//   RDATAx/ERRx           : read data / out-of-range flag, valid with ACKx,
//                           held until master x's next ACK
//   M_AD/M_WD/M_MW/M_MR   : memory address, write data, write and read enable
//   M_RD                  : memory read data (combinational from the memory)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ERR0,
  output logic          ERR1,
  output logic [AW-1:0] M_AD,
  output logic [DW-1:0] M_WD,
  output logic          M_MW,
  output logic          M_MR,
  input  logic [DW-1:0] M_RD
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q;
  logic          last_q;   // master served last; 1 after reset so master 0 wins the first tie
  logic          win_q;    // master owning the current transaction
  logic          we_q;
  logic          err_q;

  logic          win_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          ok_d;
  logic [DW-1:0] rdata_d;

  // Address lies inside the memory.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (int'(a) < DEPTH);
  endfunction

  // Pick the winner among pending requests: a lone requester wins, a tie goes to the master not served last.
  always_comb begin
    if (REQ0 && REQ1) begin
      win_d = ~last_q;
    end else if (REQ1) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
  end

  // Route the winner's request fields to the latching stage.
  always_comb begin
    if (win_d) begin
      we_d    = WE1;
      addr_d  = ADDR1;
      wdata_d = WDATA1;
    end else begin
      we_d    = WE0;
      addr_d  = ADDR0;
      wdata_d = WDATA0;
    end
    ok_d = addr_ok(addr_d);
  end

  // Read data returned to the winner: memory data for in-range reads, zero for writes and errors.
  always_comb begin
    if (!we_q && !err_q) begin
      rdata_d = M_RD;
    end else begin
      rdata_d = {DW{1'b0}};
    end
  end

  // Transaction sequencer with registered memory-port and handshake outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      ACK0    <= 1'b0;
      ACK1    <= 1'b0;
      ERR0    <= 1'b0;
      ERR1    <= 1'b0;
      RDATA0  <= {DW{1'b0}};
      RDATA1  <= {DW{1'b0}};
      M_AD    <= {AW{1'b0}};
      M_WD    <= {DW{1'b0}};
      M_MW    <= 1'b0;
      M_MR    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            state_q <= S_ACCESS;
            win_q   <= win_d;
            we_q    <= we_d;
            err_q   <= ~ok_d;
            GNT0    <= ~win_d;
            GNT1    <= win_d;
            // Address and data are driven even for out-of-range requests; only the strobes are suppressed.
            M_AD    <= addr_d;
            M_WD    <= wdata_d;
            M_MW    <= we_d & ok_d;
            M_MR    <= ~we_d & ok_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          state_q <= S_RESP;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          M_MW    <= 1'b0;
          M_MR    <= 1'b0;
          if (win_q) begin
            ACK1   <= 1'b1;
            RDATA1 <= rdata_d;
            ERR1   <= err_q;
          end else begin
            ACK0   <= 1'b1;
            RDATA0 <= rdata_d;
            ERR0   <= err_q;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ACK0    <= 1'b0;
          ACK1    <= 1'b0;
          last_q  <= win_q;
        end
        default: begin
          state_q <= S_IDLE;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          ACK0    <= 1'b0;
          ACK1    <= 1'b0;
          M_MW    <= 1'b0;
          M_MR    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A 32x8 memory model sits on the M_* port
//   (word i holds i, except word 20 which holds 0xFC). A transaction-level
//   reference model predicts every output each cycle; directed sequences add
//   hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [7:0] ADDR0 = 8'd0, ADDR1 = 8'd0, WDATA0 = 8'd0, WDATA1 = 8'd0;
  logic       GNT0, GNT1, ACK0, ACK1, ERR0, ERR1, M_MW, M_MR;
  logic [7:0] RDATA0, RDATA1, M_AD, M_WD, M_RD;
  logic       mem_load = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DEPTH(32), .AW(8), .DW(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .ERR0(ERR0), .ERR1(ERR1),
    .M_AD(M_AD), .M_WD(M_WD), .M_MW(M_MW), .M_MR(M_MR), .M_RD(M_RD)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_val(input int i);
    init_val = (i == 20) ? 8'hFC : 8'(i);
  endfunction

  // Memory attached to the arbiter: combinational read, write on the rising edge.
  logic [7:0] env_mem [0:31];
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
    end else if (M_MW && M_AD < 8'd32) begin
      env_mem[M_AD[4:0]] <= M_WD;
    end
  end
  assign M_RD = (M_AD < 8'd32) ? env_mem[M_AD[4:0]] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is alive for two cycles after the edge that samples it:
  // age 1 = memory access cycle, age 2 = acknowledge cycle.
  logic [7:0] ref_mem [0:31];
  bit         t_act, t_win, t_we, ptr;
  int         t_age;
  logic [7:0] t_addr, t_wdata;
  logic       e_gnt0, e_gnt1, e_ack0, e_ack1, e_err0, e_err1, e_mw, e_mr;
  logic [7:0] e_rd0, e_rd1, e_ad, e_wd;

  function automatic bit in_rng(input logic [7:0] a);
    in_rng = (a < 8'd32);
  endfunction

  // Compare DUT against the model each cycle, then advance the model to the next cycle.
  always @(negedge CLK) begin
    logic [7:0] rd;
    if (mem_load) for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    if (!RESET_N) begin
      t_act = 1'b0; t_age = 0; ptr = 1'b1;
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      e_err0 = 1'b0; e_err1 = 1'b0; e_mw = 1'b0; e_mr = 1'b0;
      e_rd0 = 8'h00; e_rd1 = 8'h00; e_ad = 8'h00; e_wd = 8'h00;
    end
    chk("GNT0", GNT0, e_gnt0);   chk("GNT1", GNT1, e_gnt1);
    chk("ACK0", ACK0, e_ack0);   chk("ACK1", ACK1, e_ack1);
    chk("RDATA0", RDATA0, e_rd0); chk("RDATA1", RDATA1, e_rd1);
    chk("ERR0", ERR0, e_err0);   chk("ERR1", ERR1, e_err1);
    chk("M_MW", M_MW, e_mw);     chk("M_MR", M_MR, e_mr);
    chk("M_AD", M_AD, e_ad);     chk("M_WD", M_WD, e_wd);
    if (RESET_N) begin
      if (t_act && t_age == 1) begin
        rd = (!t_we && in_rng(t_addr)) ? ref_mem[t_addr[4:0]] : 8'h00;
        if (t_we && in_rng(t_addr)) ref_mem[t_addr[4:0]] = t_wdata;
        if (t_win) begin e_rd1 = rd; e_err1 = !in_rng(t_addr); end
        else       begin e_rd0 = rd; e_err0 = !in_rng(t_addr); end
        t_age = 2;
      end else if (t_act) begin
        t_act = 1'b0;
        ptr   = t_win;
      end else if (REQ0 || REQ1) begin
        t_win   = (REQ0 && REQ1) ? !ptr : REQ1;
        t_we    = t_win ? WE1 : WE0;
        t_addr  = t_win ? ADDR1 : ADDR0;
        t_wdata = t_win ? WDATA1 : WDATA0;
        t_act   = 1'b1;
        t_age   = 1;
        e_ad    = t_addr;
        e_wd    = t_wdata;
      end
      e_gnt0 = t_act && t_age == 1 && !t_win;
      e_gnt1 = t_act && t_age == 1 && t_win;
      e_ack0 = t_act && t_age == 2 && !t_win;
      e_ack1 = t_act && t_age == 2 && t_win;
      e_mw   = t_act && t_age == 1 && t_we && in_rng(t_addr);
      e_mr   = t_act && t_age == 1 && !t_we && in_rng(t_addr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit m, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (m) begin REQ1 = r; WE1 = we; ADDR1 = a; WDATA1 = d; end
    else   begin REQ0 = r; WE0 = we; ADDR0 = a; WDATA0 = d; end
  endtask

  // One isolated transaction; lat is cycles from the sampling edge to the ACK cycle (-1 on timeout).
  task automatic txn(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d,
                     output int lat, output int gntc, output int mwc, output int mrc,
                     output logic [7:0] mwad, output logic [7:0] rd, output logic err);
    bit got;
    int k;
    @(posedge CLK); #1;
    drive(m, 1'b1, we, a, d);
    got = 1'b0; k = 0; gntc = 0; mwc = 0; mrc = 0; mwad = 8'h00; rd = 8'h00; err = 1'b0;
    while (!got && k < 10) begin
      @(negedge CLK); k++;
      if (m ? GNT1 : GNT0) gntc++;
      if (M_MW) begin mwc++; mwad = M_AD; end
      if (M_MR) mrc++;
      if (m ? ACK1 : ACK0) begin
        got = 1'b1;
        rd  = m ? RDATA1 : RDATA0;
        err = m ? ERR1 : ERR0;
      end
    end
    @(posedge CLK); #1;
    drive(m, 1'b0, 1'b0, 8'h00, 8'h00);
    lat = got ? k - 1 : -1;
  endtask

  int         lat, gntc, mwc, mrc, n;
  logic [7:0] mwad, rd;
  logic       err;
  int         order [0:3];
  logic [7:0] seen  [0:3];
  int         gcyc  [0:2];

  initial begin
    #2 RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdata0", RDATA0, 8'h00);
    chk("rst_m_ad", M_AD, 8'h00);
    mem_load = 1'b0;
    RESET_N  = 1'b1;

    // Both masters held: strictly alternating grants, master 0 first.
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd2, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd3, 8'h00);
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge CLK);
      chk("tie_ack_onehot", ACK0 & ACK1, 1'b0);
      if (ACK0 || ACK1) begin
        order[n] = ACK1 ? 1 : 0;
        seen[n]  = ACK1 ? RDATA1 : RDATA0;
        n++;
      end
    end
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("tie_count", n, 4);
    chk("tie_order0", order[0], 0); chk("tie_order1", order[1], 1);
    chk("tie_order2", order[2], 0); chk("tie_order3", order[3], 1);
    chk("tie_rd0", seen[0], 8'h02); chk("tie_rd1", seen[1], 8'h03);
    chk("tie_rd2", seen[2], 8'h02); chk("tie_rd3", seen[3], 8'h03);

    // Simple reads with latency.
    txn(1'b0, 1'b0, 8'd5, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd5_lat", lat, 2); chk("rd5_gnt_cycles", gntc, 1);
    chk("rd5_data", rd, 8'h05); chk("rd5_err", err, 1'b0); chk("rd5_mr", mrc, 1);
    txn(1'b0, 1'b0, 8'd20, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd20_data", rd, 8'hFC);

    // Write of the last valid word by master 1, then read back by master 0.
    txn(1'b1, 1'b1, 8'd31, 8'hA5, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("wr31_mw_pulses", mwc, 1); chk("wr31_ad", mwad, 8'd31);
    chk("wr31_err", err, 1'b0); chk("wr31_rdata", rd, 8'h00); chk("wr31_lat", lat, 2);
    txn(1'b0, 1'b0, 8'd31, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd31_data", rd, 8'hA5);

    // Out-of-range accesses.
    txn(1'b0, 1'b1, 8'd40, 8'h77, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("wr40_mw", mwc, 0); chk("wr40_mr", mrc, 0); chk("wr40_err", err, 1'b1);
    txn(1'b0, 1'b0, 8'd8, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd8_data", rd, 8'h08); chk("rd8_err", err, 1'b0);
    txn(1'b1, 1'b0, 8'd32, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd32_err", err, 1'b1); chk("rd32_mr", mrc, 0);
    txn(1'b1, 1'b0, 8'd255, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rd255_err", err, 1'b1); chk("rd255_data", rd, 8'h00);

    // Master 0 alone, request held: grants exactly 3 cycles apart.
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd6, 8'h00);
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge CLK);
      chk("b2b_no_gnt1", GNT1, 1'b0);
      if (GNT0) gcyc[n] = c;
      if (ACK0) begin
        chk("b2b_rd", RDATA0, 8'h06);
        n++;
      end
    end
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("b2b_count", n, 3);
    chk("b2b_gap01", gcyc[1] - gcyc[0], 3);
    chk("b2b_gap12", gcyc[2] - gcyc[1], 3);

    // Reset during the ACCESS cycle of a write: dropped, no ACK, memory untouched.
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, 1'b1, 8'd4, 8'h11);
    @(posedge CLK); #1;
    chk("rstw_pre_mw", M_MW, 1'b1);
    chk("rstw_pre_gnt", GNT0, 1'b1);
    RESET_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("rstw_mw", M_MW, 1'b0); chk("rstw_gnt", GNT0, 1'b0);
    chk("rstw_ad", M_AD, 8'h00); chk("rstw_wd", M_WD, 8'h00);
    chk("rstw_rd0", RDATA0, 8'h00);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (ACK0) n++;
    end
    chk("rstw_no_ack", n, 0);
    txn(1'b0, 1'b0, 8'd4, 8'h00, lat, gntc, mwc, mrc, mwad, rd, err);
    chk("rstw_rd4", rd, 8'h04);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer for the 32×8 single-port data memory. It accepts independent read/write requests from two masters, for example the core datapath and a debug/DMA port. It serialises them onto the memory's AD/WD/MW/MR/RD port and returns per-master acknowledges, read data and out-of-range errors. It sits directly in front of the memory; the memory's own reset is unaffected.

## Interface
- DEPTH, 32, number of valid memory words; addresses ≥ DEPTH are errors
- AW, 8, address width
- DW, 8, data width
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ0 / REQ1  in  1  request from master 0 / 1, held until ACK
- WE0 / WE1  in  1  1 = write, 0 = read
- ADDR0 / ADDR1  in  AW  word address
- WDATA0 / WDATA1  in  DW  write data
- GNT0 / GNT1  out  1  high during the memory-access cycle of that master
- ACK0 / ACK1  out  1  one-cycle completion pulse
- RDATA0 / RDATA1  out  DW  read data, valid with ACK
- ERR0 / ERR1  out  1  out-of-range flag, valid with ACK
- M_AD  out  AW  memory address
- M_WD  out  DW  memory write data
- M_MW  out  1  memory write enable
- M_MR  out  1  memory read enable
- M_RD  in  DW  memory read data (combinational from the memory)

## Operation
- FSM states:
  - IDLE → ACCESS when REQ0 or REQ1 is sampled high at a rising edge in IDLE.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- REQx is sampled only in IDLE. Requests in ACCESS/RESP wait.
- Arbitration:
  - One pending request wins.
  - When both are pending, the master not served last wins.
  - The last-served pointer resets to 1, so master 0 wins the first tie.
- On the IDLE→ACCESS edge, the winner's index, WE, ADDR and WDATA are latched. The master may change its fields after GNT.
- ACCESS, in-range address (ADDR < DEPTH):
  - M_AD = latched address.
  - Write: M_WD = data, M_MW = 1.
  - Read: M_MR = 1.
- ACCESS, out-of-range address: M_MW = M_MR = 0, and M_AD/M_WD are still driven.
- At the end of ACCESS, M_RD is captured into the winner's RDATA for in-range reads; RDATA is 0 for writes and for errors.
- RESP:
  - ACKx pulses for the winner; the other master's ACK stays 0.
  - ERRx = 1 when the address was out of range.
  - The last-served pointer updates to the winner.
- RDATAx and ERRx hold until that master's next ACK.
- All M_* outputs and GNT/ACK are registered, with no combinational path from REQ.
- Outside ACCESS: M_MW = M_MR = 0, and M_AD/M_WD hold their last values.

## Timing
- Reset (RESET_N low, asynchronous) forces:
  - FSM to IDLE and pointer to 1.
  - GNT0/1, ACK0/1, ERR0/1, M_MW, M_MR to 0.
  - RDATA0/1, M_AD, M_WD to 0.
- Reset mid-transaction drops the transaction. A write whose ACCESS cycle is cut by reset is not committed, and no ACK is issued.
- Latency from REQ sampled (edge t) to ACK high is 2 cycles:
  - ACCESS occupies cycle t+1.
  - ACK is high in cycle t+2.
- Throughput is one transaction per 3 cycles.
- Handshake:
  - The master holds REQ/WE/ADDR/WDATA until GNT.
  - The master must drop REQ by the IDLE cycle after ACK; REQ still high at that edge is a new request.
- Simultaneous REQ0 and REQ1 held continuously produce strictly alternating grants: 0, 1, 0, 1…
- The memory write commits on the rising edge ending ACCESS. A read issued by the other master in the next transaction sees the new data.
- Address DEPTH-1 (31) is valid; DEPTH (32) and 255 are errors.

## Test plan
- After reset, master 0 reads addr 5 → GNT0 1 cycle, ACK0 2 cycles after sampling, RDATA0 = 0x05, ERR0 = 0; master 0 reads addr 20 → RDATA0 = 0xFC.
- Master 1 writes 0xA5 to addr 31, then master 0 reads addr 31 → M_MW pulses once with M_AD = 31; RDATA0 = 0xA5.
- REQ0 and REQ1 both held for 4 transactions (reads of addrs 2 and 3) → grant order 0, 1, 0, 1; RDATA0 = 0x02, RDATA1 = 0x03; each ACK lasts exactly 1 cycle.
- Master 0 writes 0x77 to addr 40 → M_MW and M_MR stay 0, ACK0 with ERR0 = 1; a following read of addr 8 → 0x08, ERR0 = 0.
- Master 0 writes 0x11 to addr 4, and RESET_N is pulsed low during ACCESS → all outputs 0 immediately, no ACK0; after release, a read of addr 4 returns 0x04.
- Master 1 is idle, and master 0 issues 3 back-to-back reads → all granted to 0, spaced exactly 3 cycles apart.
